// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction field layout.
// Used by the fetch unit, the IO loader and the core decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F0    = 3'd1,
        F1    = 3'd2,
        F2    = 3'd3,
        VALID = 3'd4
    } fetch_state_t;

    localparam int OPCODE_W     = 8;
    localparam int OPERAND8_W   = 8;
    localparam int OPERAND16_W  = 16;
    localparam int OPCODE_LSB   = 24;
    localparam int OPERAND8_LSB = 16;

endpackage

// File: rtl/instr_fetch.sv
// Sequential instruction fetcher: reads two RAM words per instruction and
// hands the assembled 32-bit instruction to the core via valid/ready.
import cpu_pkg::*;

module instr_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_W-1:0]     address,
    output logic                  wren,
    input  logic [DATA_W-1:0]     q,
    input  logic                  pc_load,
    input  logic [ADDR_W-1:0]     pc_load_value,
    output logic [2*DATA_W-1:0]   instr,
    output logic [ADDR_W-1:0]     instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_TWO = {{(ADDR_W-2){1'b0}}, 2'b10};

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;

    assign wren = 1'b0;

    // Fetch FSM, PC register and registered instruction outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            address     <= RESET_PC;
            instr       <= {(2*DATA_W){1'b0}};
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (!enable) begin
            // pc is kept so re-enabling refetches an unconsumed instruction
            r_state     <= IDLE;
            instr_valid <= 1'b0;
        end else if (pc_load) begin
            r_pc        <= pc_load_value;
            address     <= pc_load_value;
            instr_valid <= 1'b0;
            r_state     <= F0;
        end else begin
            case (r_state)
                IDLE: begin
                    address <= r_pc;
                    r_state <= F0;
                end
                F0: begin
                    address <= r_pc + PC_ONE;
                    r_state <= F1;
                end
                F1: begin
                    instr[2*DATA_W-1:DATA_W] <= q;
                    r_state                  <= F2;
                end
                F2: begin
                    instr[DATA_W-1:0] <= q;
                    instr_pc          <= r_pc;
                    instr_valid       <= 1'b1;
                    r_state           <= VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        r_pc        <= r_pc + PC_TWO;
                        address     <= r_pc + PC_TWO;
                        instr_valid <= 1'b0;
                        r_state     <= F0;
                    end else begin
                        r_state <= VALID;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a 1-cycle-latency RAM model.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] address;
    logic        wren;
    logic [15:0] q;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [15:0] mem [0:65535];
    logic        wren_seen;
    int          n_checks;
    int          n_pass;

    typedef struct {
        logic [15:0] load_pc;
        logic [31:0] exp_instr;
        logic [15:0] exp_next_pc;
        logic [31:0] exp_next_instr;
    } vec_t;

    vec_t vecs [4];

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .address       (address),
        .wren          (wren),
        .q             (q),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port with one cycle of latency
    always @(posedge clk) q <= mem[address];

    // wren must never assert
    always @(negedge clk) if (wren !== 1'b0) wren_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_valid(input int max_edges, output int n);
        n = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [31:0] held_instr;
        n_checks = 0;
        n_pass = 0;
        wren_seen = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = a[15:0];
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;

        vecs[0] = '{16'h0040, 32'h0040_0041, 16'h0042, 32'h0042_0043};
        vecs[1] = '{16'hFFFF, 32'hAB00_00CD, 16'h0001, 32'h5678_0002};
        vecs[2] = '{16'h1234, 32'h1234_1235, 16'h1236, 32'h1236_1237};
        vecs[3] = '{16'hFFFE, 32'hFFFE_AB00, 16'h0000, 32'h00CD_5678};

        reset = 1'b0; enable = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0000;
        instr_ready = 1'b0;
        tick(); tick();
        check("reset_address", {16'h0, address}, 32'h0);
        check("reset_instr", instr, 32'h0);
        check("reset_instr_pc", {16'h0, instr_pc}, 32'h0);
        check("reset_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_wren", {31'h0, wren}, 32'h0);

        // first fetch: valid on the 4th edge after enable
        reset = 1'b1; enable = 1'b1;
        wait_valid(10, n);
        check("first_latency", n, 32'd4);
        check("first_instr", instr, 32'h1234_5678);
        check("first_instr_pc", {16'h0, instr_pc}, 32'h0);

        // backpressure: everything holds for 10 cycles
        held_instr = instr;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'h0, instr_valid}, 32'h1);
            check("bp_instr", instr, held_instr);
            check("bp_address", {16'h0, address}, 32'h1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("hs_valid_drop", {31'h0, instr_valid}, 32'h0);
        check("hs_address", {16'h0, address}, 32'h2);
        wait_valid(10, n);
        check("second_latency", n, 32'd3);
        check("second_instr_pc", {16'h0, instr_pc}, 32'h2);
        check("second_instr", instr, 32'h0002_0003);

        // jump while in F1: the old fetch must not surface
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        check("f1_no_valid", {31'h0, instr_valid}, 32'h0);
        pc_load = 1'b1; pc_load_value = 16'h0040;
        tick();
        pc_load = 1'b0;
        wait_valid(10, n);
        check("jump_latency", n, 32'd3);
        check("jump_instr_pc", {16'h0, instr_pc}, 32'h40);
        check("jump_instr", instr, 32'h0040_0041);

        mem[16'h0000] = 16'h00CD;
        mem[16'hFFFF] = 16'hAB00;
        for (int v = 0; v < 4; v++) begin
            pc_load = 1'b1; pc_load_value = vecs[v].load_pc;
            tick();
            pc_load = 1'b0;
            wait_valid(10, n);
            check("tbl_latency", n, 32'd3);
            check("tbl_instr", instr, vecs[v].exp_instr);
            check("tbl_instr_pc", {16'h0, instr_pc}, {16'h0, vecs[v].load_pc});
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            wait_valid(10, n);
            check("tbl_next_latency", n, 32'd3);
            check("tbl_next_instr_pc", {16'h0, instr_pc}, {16'h0, vecs[v].exp_next_pc});
            check("tbl_next_instr", instr, vecs[v].exp_next_instr);
        end

        // mode toggle during F2; pc_load ignored while disabled
        pc_load = 1'b1; pc_load_value = 16'h0004;
        tick();
        pc_load = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        pc_load = 1'b1; pc_load_value = 16'h0100;
        tick();
        check("off_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        tick();
        check("off_valid_held", {31'h0, instr_valid}, 32'h0);
        pc_load = 1'b0;
        enable = 1'b1;
        wait_valid(10, n);
        check("reenable_latency", n, 32'd4);
        check("reenable_instr_pc", {16'h0, instr_pc}, 32'h4);
        check("reenable_instr", instr, 32'h0004_0005);

        // synchronous reset mid-VALID takes effect on the edge, not before
        reset = 1'b0;
        #1;
        check("prereset_valid", {31'h0, instr_valid}, 32'h1);
        check("prereset_instr_pc", {16'h0, instr_pc}, 32'h4);
        tick();
        check("sreset_address", {16'h0, address}, 32'h0);
        check("sreset_instr", instr, 32'h0);
        check("sreset_instr_pc", {16'h0, instr_pc}, 32'h0);
        check("sreset_valid", {31'h0, instr_valid}, 32'h0);
        enable = 1'b0;
        reset = 1'b1;
        tick();
        check("wren_never", {31'h0, wren_seen}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Read side of the shared program RAM: sequential instruction-fetch unit used by the core in execute mode.
- The IO block writes 16-bit words into the RAM in io-mode; this block reads them back in pairs.
- Each pair is assembled into one 32-bit instruction and presented to the core decoder through a valid/ready handshake.
- Sits between the RAM port mux (address/wren) and the core's execute stage. Supports PC load for jumps.

Parameters:
- ADDR_W, 16, RAM address width and PC width.
- DATA_W, 16, RAM word width; an instruction is 2*DATA_W bits.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous reset, active-low: reset==0 at a rising edge resets the block.
- enable  in  1  execute-mode gate (SW[17]); 0 aborts and idles the fetcher.
- address  out  ADDR_W  RAM read address; registered.
- wren  out  1  RAM write enable; constant 0.
- q  in  DATA_W  RAM read data, valid the cycle after the RAM samples the address (1-cycle latency).
- pc_load  in  1  load a new PC (jump/branch) this cycle.
- pc_load_value  in  ADDR_W  target PC.
- instr  out  2*DATA_W  {word@pc, word@pc+1}; opcode=[31:24], operand8=[23:16], operand16=[15:0].
- instr_pc  out  ADDR_W  address of the first word of instr.
- instr_valid  out  1  instr holds a complete instruction.
- instr_ready  in  1  core accepts instr when valid&ready at a rising edge.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, address=RESET_PC, instr=0, instr_pc=RESET_PC, instr_valid=0. wren is always 0.
- States and transitions:
  - IDLE: if enable, address<=pc, go F0.
  - F0: RAM samples pc. address<=pc+1, go F1.
  - F1: q=mem[pc]; instr[31:16]<=q. RAM samples pc+1. Go F2.
  - F2: q=mem[pc+1]; instr[15:0]<=q, instr_pc<=pc, instr_valid<=1. Go VALID.
  - VALID: hold instr and instr_valid stable until handshake. On valid&ready: pc<=pc+2, address<=pc+2, instr_valid<=0, go F0.
- Latency: 4 edges from enable rising in IDLE to instr_valid=1. 3 edges from handshake to the next instr_valid. No overlap between fetches.
- Address arithmetic: modulo 2^ADDR_W. pc=16'hFFFF fetches FFFF then 0000; the next pc is 0001.
- pc_load, any state except IDLE-with-enable=0:
  - pc<=pc_load_value, address<=pc_load_value, instr_valid<=0, go F0.
  - Any in-flight fetch is discarded and no partial word is kept.
- pc_load together with a handshake in VALID: the handshake completes (instruction consumed) and the load wins the PC (no +2).
- enable=0 in any state (highest priority after reset): instr_valid<=0, go IDLE.
  - pc is kept unchanged, so re-enable refetches the unconsumed instruction.
  - pc_load is ignored while enable=0.
- Reset mid-fetch: all state returns to reset values on that edge.
- instr, instr_pc and instr_valid are registered outputs; none is combinationally dependent on inputs.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum (IDLE, F0, F1, F2, VALID);
  - OPCODE_W=8, OPERAND8_W=8, OPERAND16_W=16;
  - field offsets OPCODE_LSB=24, OPERAND8_LSB=16.
- The IO block and the core decoder use the same package.
- No sub-module: a single FSM plus a PC register is the natural size.

Test Plan:
- Reset then fetch: mem[0]=16'h1234, mem[1]=16'h5678, enable=1, ready=1.
  - Required: instr_valid rises on the 4th edge, instr=32'h12345678, instr_pc=0.
  - Required: the next instr_pc=2, valid 3 edges after the handshake.
- Backpressure: ready=0 for 10 cycles in VALID.
  - Required: instr and instr_valid stay stable and address does not change.
  - Then ready=1 for one edge: exactly one handshake, pc=2.
- Jump mid-fetch: assert pc_load with value 16'h0040 while in F1.
  - Required: no valid is produced from the old pc.
  - Required: the next instr_pc=16'h0040, with {mem[40],mem[41]}.
- Wrap: pc_load 16'hFFFF, mem[FFFF]=16'hAB00, mem[0]=16'h00CD.
  - Required: instr=32'hAB0000CD, then instr_pc=16'h0001.
- Mode toggle: enable=0 during F2 after pc=4.
  - Required: IDLE, instr_valid=0.
  - On re-enable, instr_pc=4 after 4 edges.
- Sync reset: drive reset=0 mid-VALID for one edge.
  - Required: all outputs return to reset values on that edge and not before. wren stays 0 throughout.
